sample_window_feeder: RTL and testbench
=======================================

// Module: sample_window_feeder
// PURPOSE
//  Writer side of the moving-average datapath. Accepts a stream of signed samples through a
//  valid/ready handshake and maintains the sample history (current sample plus REG_SIZE previous)
//  that drives the `average` adder tree. History slots beyond the active window are zeroed.
//  Produces a valid flag delayed to line up with the averager's registered output.
// PARAMETERS
//  REG_SIZE   127  previous-sample slots; REG_SIZE+1 must be a power of 2 (2..128)
//  BIT_WIDTH  16   sample width, two's complement
//  LATENCY    localparam = $clog2(REG_SIZE+1); adder-tree depth of the averager
// PORTS
//  clk          in   1               clock; all state on rising edge
//  rst          in   1               synchronous reset, active-high
//  sampleSize   in   32              window length: 2,4,8,16,32,64,128 (<= REG_SIZE+1)
//  in_valid     in   1               sample offered
//  in_ready     out  1               sample accepted when in_valid & in_ready
//  din          in   BIT_WIDTH       sample
//  cur_data     out  BIT_WIDTH       newest accepted sample -> averager din
//  prevDataReg  out  BIT_WIDTH x REG_SIZE  history; [0] = sample before cur_data
//  window_full  out  1               sampleSize samples held since last clear
//  fill_count   out  $clog2(REG_SIZE+1)+1  samples held, saturates at sampleSize
//  avg_valid    out  1               averager dout valid this cycle
// BEHAVIOUR
//  - Reset: cur_data=0, prevDataReg all 0, fill_count=0, window_full=0, avg_valid=0,
//    in_ready=0 during reset, then state FILL. rst mid-operation discards everything.
//  - Effective size N: sampleSize when in the legal set, otherwise 4. It is sampled every cycle.
//  - Accept (in_valid & in_ready), cycle t: at t+1 cur_data=din; prevDataReg[0]=old cur_data;
//    prevDataReg[k]=old prevDataReg[k-1] for k<N-1; prevDataReg[k]=0 for k>=N-1.
//    There is no shift without an accept.
//  - States:
//    FILL : in_ready=1; fill_count++ per accept; when it reaches N -> RUN, window_full=1.
//    RUN  : in_ready=1; fill_count holds at N.
//    CLEAR: entered from FILL/RUN when N differs from the registered N.
//           Lasts one cycle: in_ready=0; cur_data and prevDataReg zeroed; fill_count=0;
//           window_full=0; valid pipeline flushed. Then -> FILL.
//           An in_valid in the change cycle is not accepted.
//  - avg_valid: a LATENCY+1-deep shift pipeline. It is loaded with (accept & the post-accept
//    count == N), so an accept at t gives avg_valid at t+1+LATENCY. One pulse per qualifying
//    accept; back-to-back accepts give back-to-back pulses.
//  - Widths: no arithmetic on samples; data is moved bit-exact. Sign is preserved.
//    fill_count compares unsigned.
// STRUCTURE
//  - Shared pkg avg_pkg: MAX_WINDOW=128, the legal sampleSize set, and function
//    eff_size(sampleSize) (default 4). The averager's log2 decode uses the same function.
//  - One state enum {FILL, RUN, CLEAR} lives in avg_pkg.
//  - One sub-module, valid_delay_line #(DEPTH=LATENCY+1). It is a resettable 1-bit shift
//    pipeline with a synchronous flush.
// TESTING (REG_SIZE=7, BIT_WIDTH=16, LATENCY=3)
//  1 Reset, sampleSize=4, feed 1,2,3,4 at cycles 0..3 -> window_full at cycle 4;
//    cur_data=4, prev={3,2,1,0,0,0,0}; avg_valid high at cycle 7 only, and averager dout=2.
//  2 sampleSize=4, feed 0xFFFC x4 -> prev[0..2]=0xFFFC, prev[3..6]=0; averager dout=0xFFFC (-4).
//  3 RUN at size 4, switch sampleSize to 8 -> one cycle in_ready=0, all history 0,
//    pending avg_valid dropped; next avg_valid 4 cycles after the 8th new accept.
//  4 sampleSize=5 -> identical outputs to sampleSize=4 for the same stimulus.
//  5 rst asserted after 2 of 4 samples -> next cycle all outputs 0, fill_count=0;
//    4 further samples are needed for avg_valid.
//  6 in_valid toggled 1,0,1,0 -> history shifts only on accepts; avg_valid pulses
//    are spaced two cycles apart.

Source files
------------

// File: rtl/avg_pkg.sv
// Types and helpers shared by the moving-average writer and the averager.
// eff_size() is the single decode of the requested window length.
package avg_pkg;

  localparam logic [31:0] MAX_WINDOW     = 32'd128;
  localparam logic [31:0] DEFAULT_WINDOW = 32'd4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } fsm_state_e;

  // Power-of-two lengths up to max_n pass through; anything else falls back to 4.
  function automatic logic [31:0] eff_size(input logic [31:0] size,
                                           input logic [31:0] max_n = MAX_WINDOW);
    logic [31:0] res;
    if ((size inside {32'd2, 32'd4, 32'd8, 32'd16, 32'd32, 32'd64, 32'd128}) && (size <= max_n)) begin
      res = size;
    end else begin
      res = DEFAULT_WINDOW;
    end
    return res;
  endfunction

endpackage

// File: rtl/sample_window_feeder_if.sv
// Sample stream handshake into the window feeder.
interface sample_window_feeder_if #(
  parameter int BIT_WIDTH = 16
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] din;

  modport master (output in_valid, output din, input in_ready);
  modport slave  (input in_valid, input din, output in_ready);

endinterface

// File: rtl/valid_delay_line.sv
// One-bit shift pipeline that lines the valid flag up with the averager output.
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] pipe_r;

  // Shift register; reset and flush both empty it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pipe_r <= '0;
    end else begin
      pipe_r <= {pipe_r[DEPTH-2:0], din};
    end
  end

  assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/sample_window_feeder.sv
// Writer side of the moving-average datapath: keeps the sample history window,
// restarts it when the window length changes, and times the output-valid flag.
module sample_window_feeder
  import avg_pkg::*;
#(
  parameter int REG_SIZE  = 127,
  parameter int BIT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 sampleSize,
  sample_window_feeder_if.slave       s_if,
  output logic [BIT_WIDTH-1:0]        cur_data,
  output logic [BIT_WIDTH-1:0]        prevDataReg [REG_SIZE],
  output logic                        window_full,
  output logic [$clog2(REG_SIZE+1):0] fill_count,
  output logic                        avg_valid
);

  localparam int LATENCY = $clog2(REG_SIZE + 1);
  localparam int CW      = LATENCY + 1;

  fsm_state_e    state_r, state_s, state_nxt_s;
  logic [CW-1:0] n_s, n_r, count_nxt_s;
  logic          in_valid_s, ready_s, accept_s, load_s, flush_s;

  assign n_s        = CW'(eff_size(sampleSize, 32'(REG_SIZE + 1)));
  assign in_valid_s = s_if.in_valid & ~rst;

  // Next state and handshake; a length change turns the current cycle into CLEAR.
  always_comb begin
    state_s     = (n_s != n_r) ? CLEAR : state_r;
    state_nxt_s = FILL;
    ready_s     = 1'b0;
    accept_s    = 1'b0;
    flush_s     = 1'b0;
    count_nxt_s = fill_count;
    case (state_s)
      FILL: begin
        ready_s     = 1'b1;
        accept_s    = in_valid_s;
        count_nxt_s = fill_count + CW'(1);
        if (accept_s && (count_nxt_s == n_r)) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = FILL;
        end
      end
      RUN: begin
        ready_s     = 1'b1;
        accept_s    = in_valid_s;
        state_nxt_s = RUN;
      end
      CLEAR: begin
        flush_s     = 1'b1;
        state_nxt_s = FILL;
      end
      default: begin
        flush_s     = 1'b1;
        state_nxt_s = FILL;
      end
    endcase
    load_s = accept_s && (count_nxt_s == n_r);
  end

  assign s_if.in_ready = ready_s & ~rst;

  // State, registered window length and the history shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= FILL;
      n_r         <= n_s;
      cur_data    <= '0;
      fill_count  <= '0;
      window_full <= 1'b0;
      for (int k = 0; k < REG_SIZE; k++) begin
        prevDataReg[k] <= '0;
      end
    end else begin
      state_r <= state_nxt_s;
      n_r     <= n_s;
      if (flush_s) begin
        cur_data    <= '0;
        fill_count  <= '0;
        window_full <= 1'b0;
        for (int k = 0; k < REG_SIZE; k++) begin
          prevDataReg[k] <= '0;
        end
      end else if (accept_s) begin
        cur_data       <= s_if.din;
        prevDataReg[0] <= cur_data;
        // Slots past the active window are forced to zero so the adder tree sees only N samples.
        for (int k = 1; k < REG_SIZE; k++) begin
          if (k < int'(n_r) - 1) begin
            prevDataReg[k] <= prevDataReg[k-1];
          end else begin
            prevDataReg[k] <= '0;
          end
        end
        fill_count  <= count_nxt_s;
        window_full <= (count_nxt_s == n_r);
      end
    end
  end

  valid_delay_line #(
    .DEPTH(LATENCY + 1)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .flush(flush_s),
    .din  (load_s),
    .dout (avg_valid)
  );

endmodule

// File: tb/tb_sample_window_feeder.sv
// Directed bench for sample_window_feeder (REG_SIZE=7): stimulus pushes expected averager
// pulses into a queue, a negedge monitor pops them when avg_valid is seen.
module tb_sample_window_feeder;

  localparam int RS  = 7;
  localparam int LAT = 3;

  typedef struct {
    int due;
    int lg;
    int ea;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sampleSize;
  logic [15:0] cur_data;
  logic [15:0] prev [RS];
  logic        window_full;
  logic [3:0]  fill_count;
  logic        avg_valid;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   hist [1024];
  exp_t exp_q [$];
  int   mon_sum;
  exp_t mon_e;

  sample_window_feeder_if #(.BIT_WIDTH(16)) vif ();

  sample_window_feeder #(.REG_SIZE(RS), .BIT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sampleSize (sampleSize),
    .s_if       (vif),
    .cur_data   (cur_data),
    .prevDataReg(prev),
    .window_full(window_full),
    .fill_count (fill_count),
    .avg_valid  (avg_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Averager model: window sum per cycle, divided when the pulse arrives LAT cycles later.
  always @(negedge clk) begin
    mon_sum = $signed(cur_data);
    for (int k = 0; k < RS; k++) mon_sum = mon_sum + $signed(prev[k]);
    hist[cyc % 1024] = mon_sum;
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL avg_valid_missing: pulse due at cycle %0d not seen by cycle %0d", exp_q[0].due, cyc);
      void'(exp_q.pop_front());
    end
    if (avg_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL avg_valid_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("avg_valid_cycle", cyc, mon_e.due);
        chk("avg_dout", hist[(cyc - LAT) % 1024] >>> mon_e.lg, mon_e.ea);
      end
    end
  end

  task automatic feed(input logic [15:0] v, input bit q, input int lg, input int ea);
    exp_t e;
    @(negedge clk);
    vif.in_valid = 1'b1;
    vif.din      = v;
    @(posedge clk);
    #1;
    vif.in_valid = 1'b0;
    if (q) begin
      e.due = cyc + LAT;
      e.lg  = lg;
      e.ea  = ea;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_hist(input string tag, input int c, input int p[RS]);
    chk({tag, "_cur"}, cur_data, c);
    for (int k = 0; k < RS; k++) chk($sformatf("%s_prev%0d", tag, k), prev[k], p[k]);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_ready"}, vif.in_ready, 0);
    chk({tag, "_fill"}, fill_count, 0);
    chk({tag, "_full"}, window_full, 0);
    chk({tag, "_avg_valid"}, avg_valid, 0);
    chk_hist(tag, 0, '{0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    sampleSize   = 32'd4;
    vif.in_valid = 1'b0;
    vif.din      = 16'd0;
    idle(2);
    chk("reset_ready", vif.in_ready, 0);
    chk("reset_fill", fill_count, 0);
    chk("reset_full", window_full, 0);
    chk("reset_avg_valid", avg_valid, 0);
    chk_hist("reset", 0, '{0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    chk("ready_after_reset", vif.in_ready, 1);

    // 1: basic fill at N=4, average (1+2+3+4)/4 = 2
    feed(16'd1, 1'b0, 0, 0);
    feed(16'd2, 1'b0, 0, 0);
    feed(16'd3, 1'b0, 0, 0);
    chk("t1_full_early", window_full, 0);
    chk("t1_fill3", fill_count, 3);
    feed(16'd4, 1'b1, 2, 2);
    chk("t1_full", window_full, 1);
    chk("t1_fill", fill_count, 4);
    chk_hist("t1", 4, '{3, 2, 1, 0, 0, 0, 0});
    idle(6);

    // 2: negative samples keep their sign bits exactly
    do_reset("t2_rst");
    repeat (3) feed(16'hFFFC, 1'b0, 0, 0);
    feed(16'hFFFC, 1'b1, 2, -4);
    chk_hist("t2", 16'hFFFC, '{16'hFFFC, 16'hFFFC, 16'hFFFC, 0, 0, 0, 0});
    idle(6);

    // 3: a pending pulse is dropped when the length changes to 8
    feed(16'd5, 1'b0, 0, 0);
    @(negedge clk);
    sampleSize   = 32'd8;
    vif.in_valid = 1'b1;
    vif.din      = 16'd9;
    #1;
    chk("t3_ready_change", vif.in_ready, 0);
    @(posedge clk);
    #1;
    vif.in_valid = 1'b0;
    chk("t3_ready_after", vif.in_ready, 1);
    chk("t3_fill", fill_count, 0);
    chk("t3_full", window_full, 0);
    chk_hist("t3_clear", 0, '{0, 0, 0, 0, 0, 0, 0});
    idle(6);
    for (int v = 1; v < 8; v++) feed(16'(v), 1'b0, 0, 0);
    chk("t3_full_early", window_full, 0);
    feed(16'd8, 1'b1, 3, 4);
    chk("t3_full8", window_full, 1);
    chk("t3_fill8", fill_count, 8);
    chk_hist("t3", 8, '{7, 6, 5, 4, 3, 2, 1});
    idle(6);

    // 4: illegal length 5 behaves as 4
    @(negedge clk);
    sampleSize = 32'd5;
    idle(1);
    chk("t4_fill", fill_count, 0);
    chk_hist("t4_clear", 0, '{0, 0, 0, 0, 0, 0, 0});
    feed(16'd1, 1'b0, 0, 0);
    feed(16'd2, 1'b0, 0, 0);
    feed(16'd3, 1'b0, 0, 0);
    feed(16'd4, 1'b1, 2, 2);
    chk("t4_full", window_full, 1);
    chk_hist("t4", 4, '{3, 2, 1, 0, 0, 0, 0});
    idle(6);

    // 5: reset after two samples discards them
    do_reset("t5_rst0");
    feed(16'd10, 1'b0, 0, 0);
    feed(16'd20, 1'b0, 0, 0);
    do_reset("t5_rst1");
    feed(16'd6, 1'b0, 0, 0);
    feed(16'd6, 1'b0, 0, 0);
    feed(16'd6, 1'b0, 0, 0);
    chk("t5_full_early", window_full, 0);
    chk("t5_fill3", fill_count, 3);
    idle(6);
    feed(16'd6, 1'b1, 2, 6);
    chk("t5_full", window_full, 1);

    // 6: gaps between accepts, pulses two cycles apart
    feed(16'd10, 1'b1, 2, 7);
    idle(1);
    chk("t6_hold_cur", cur_data, 10);
    chk("t6_hold_prev0", prev[0], 6);
    feed(16'd14, 1'b1, 2, 9);
    idle(1);
    feed(16'd2, 1'b1, 2, 8);
    idle(1);
    chk_hist("t6", 2, '{14, 10, 6, 0, 0, 0, 0});
    chk("t6_fill", fill_count, 4);
    idle(6);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
